// File: rtl/kogge_stone_adder.sv
// Registered Kogge-Stone parallel-prefix adder: {cout, sum} <= A + B + cin.
// The carry-in is folded into bit 0's generate, so log2(WIDTH) radix-2 levels cover every carry.
module kogge_stone_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int LEVELS = $clog2(WIDTH);

  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_carry;
  logic [WIDTH-1:0] w_sum_nxt;
  logic             w_cout_nxt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  assign w_p = A ^ B;

  for (genvar k = 0; k <= LEVELS; k++) begin : g_lvl
    logic [WIDTH-1:0] w_gen;
    logic [WIDTH-1:0] w_prp;
    if (k == 0) begin : g_base
      assign w_gen[0] = (A[0] & B[0]) | (w_p[0] & cin);
      assign w_gen[WIDTH-1:1] = A[WIDTH-1:1] & B[WIDTH-1:1];
      assign w_prp = w_p;
    end else begin : g_comb
      localparam int D = 1 << (k - 1);
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i >= D) begin : g_merge
          assign w_gen[i] = g_lvl[k-1].w_gen[i]
                          | (g_lvl[k-1].w_prp[i] & g_lvl[k-1].w_gen[i-D]);
          assign w_prp[i] = g_lvl[k-1].w_prp[i] & g_lvl[k-1].w_prp[i-D];
        end else begin : g_pass
          assign w_gen[i] = g_lvl[k-1].w_gen[i];
          assign w_prp[i] = g_lvl[k-1].w_prp[i];
        end
      end
    end
  end

  // Carry into bit i is the group generate of bits i-1..0, which already includes cin.
  assign w_carry    = {g_lvl[LEVELS].w_gen[WIDTH-2:0], cin};
  assign w_sum_nxt  = w_p ^ w_carry;
  assign w_cout_nxt = g_lvl[LEVELS].w_gen[WIDTH-1];

  // Result register; reset clears outputs immediately and drops any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum  <= {WIDTH{1'b0}};
      r_cout <= 1'b0;
    end else begin
      r_sum  <= w_sum_nxt;
      r_cout <= w_cout_nxt;
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_kogge_stone_adder.sv
// Randomized scoreboard bench for kogge_stone_adder (WIDTH = 16).
module tb_kogge_stone_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         cin = 1'b0;
  logic [W-1:0] sum;
  logic         cout;

  logic [W:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  kogge_stone_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .cin(cin), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got cout=%0b sum=%h, expected cout=%0b sum=%h",
               name, act[W], act[W-1:0], exp[W], exp[W-1:0]);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    logic [W:0] r;
    r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    return r;
  endfunction

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    @(negedge clk);
    A = a; B = b; cin = c;
    exp_q.push_back(model(a, b, c));
  endtask

  // Monitor: every edge taken out of reset presents one result for the oldest issued vector.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() != 0) begin
        logic [W:0] e;
        e = exp_q.pop_front();
        check("result", {cout, sum}, e);
      end
    end
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc;
    #2;
    A = 16'hFFFF; B = 16'h0001; cin = 1'b0;
    rst_n = 1'b0;
    #1;
    check("reset_async", {cout, sum}, 17'h0_0000);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("reset_hold_pos", {cout, sum}, 17'h0_0000);
      @(negedge clk); #1;
      check("reset_hold_neg", {cout, sum}, 17'h0_0000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(17'h1_0000);

    issue(16'hFFFF, 16'h0000, 1'b1);
    issue(16'hFFFF, 16'hFFFF, 1'b1);
    issue(16'h0000, 16'h0000, 1'b0);
    issue(16'h1234, 16'h4321, 1'b0);
    issue(16'hAAAA, 16'h5555, 1'b0);
    issue(16'hAAAA, 16'h5555, 1'b1);
    issue(16'h8000, 16'h8000, 1'b0);
    issue(16'h7FFF, 16'h0000, 1'b1);

    for (int i = 0; i < 200; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom_range(1, 0));
      issue(ra, rb, rc);
      if (i == 120) begin
        // Abort an in-flight vector with a reset pulse between edges.
        issue(16'hFFFF, 16'hFFFF, 1'b1);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midreset_async", {cout, sum}, 17'h0_0000);
        @(posedge clk); #1;
        check("midreset_hold", {cout, sum}, 17'h0_0000);
        @(negedge clk);
        rst_n = 1'b1;
        A = 16'h00FF; B = 16'h0F01; cin = 1'b1;
        exp_q.push_back(model(16'h00FF, 16'h0F01, 1'b1));
      end
    end

    for (int t = 0; t < 10 && exp_q.size() != 0; t++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
